johnson_phase_decoder: RTL and testbench

Downstream consumer of the 4-bit Johnson (twisted-ring) counter. Samples the counter's `q[3:0]` every clock and decodes it into a phase index and one-hot phase strobes. Checks that the sequence advances legally, acquires lock after a run of correct steps, and counts full revolutions. Raises a sticky fault if the sequence breaks while locked; the fault holds until software clears it.

---
 rtl/johnson_phase_decoder.sv | 165 ++++++++++++++++
 tb/tb_johnson_phase_decoder.sv | 226 ++++++++++++++++++++++
 2 files changed

// File: rtl/johnson_phase_decoder.sv
// Johnson counter phase decoder: decodes the 4-bit twisted-ring code into a
// phase index and one-hot strobes, tracks lock, counts revolutions, flags faults.
//
// Ports:
//   c        clock, rising edge
//   r        asynchronous active-high reset
//   q        Johnson counter state, sampled every edge
//   clr_err  synchronous fault clear, only acted on in FAULT
//   idx      decoded index of the last legal sample (holds on illegal)
//   phase    one-hot of idx, zero when the last sample was illegal
//   valid    last sample was a legal code
//   locked   FSM is in LOCKED
//   err      sticky fault, set by a broken sequence while locked
//   rev_cnt  revolutions counted while locked (wraps)
//   rev_p    one-cycle pulse per counted revolution
module johnson_phase_decoder #(
   parameter int LOCK_COUNT = 4,
   parameter int CW         = 8
) (
   input  logic          c,
   input  logic          r,
   input  logic [3:0]    q,
   input  logic          clr_err,
   output logic [2:0]    idx,
   output logic [7:0]    phase,
   output logic          valid,
   output logic          locked,
   output logic          err,
   output logic [CW-1:0] rev_cnt,
   output logic          rev_p
);

   typedef enum logic [1:0] {
      S_SEARCH,
      S_TRACK,
      S_LOCKED,
      S_FAULT
   } state_t;

   localparam logic [7:0] LOCK_N = 8'(LOCK_COUNT);

   state_t          state_q, state_d;
   logic [7:0]      good_q, good_d;
   logic [2:0]      idx_q, idx_d;
   logic [7:0]      phase_q, phase_d;
   logic            valid_q, valid_d;
   logic            locked_q, locked_d;
   logic            err_q, err_d;
   logic [CW-1:0]   rev_q, rev_d;
   logic            rev_p_q, rev_p_d;

   logic            legal;
   logic [2:0]      dec_idx;
   logic            step_ok;
   logic            wrap;

   always_comb begin
      legal   = 1'b1;
      dec_idx = 3'd0;
      case (q)
         4'b1000: dec_idx = 3'd0;
         4'b1100: dec_idx = 3'd1;
         4'b1110: dec_idx = 3'd2;
         4'b1111: dec_idx = 3'd3;
         4'b0111: dec_idx = 3'd4;
         4'b0011: dec_idx = 3'd5;
         4'b0001: dec_idx = 3'd6;
         4'b0000: dec_idx = 3'd7;
         default: legal   = 1'b0;
      endcase
   end

   // valid_q doubles as "previous sample was legal"; idx_q is only
   // meaningful as the previous index when valid_q is set.
   assign step_ok = legal & valid_q & (dec_idx == idx_q + 3'd1);
   assign wrap    = step_ok & (dec_idx == 3'd0);

   always_comb begin
      state_d = state_q;
      good_d  = good_q;
      err_d   = err_q;
      rev_d   = rev_q;
      rev_p_d = 1'b0;
      unique case (state_q)
         S_SEARCH: begin
            if (legal) begin
               state_d = S_TRACK;
               good_d  = 8'd0;
            end
         end
         S_TRACK: begin
            if (step_ok) begin
               good_d = good_q + 8'd1;
               if (good_d == LOCK_N) begin
                  state_d = S_LOCKED;
               end
            end else begin
               state_d = S_SEARCH;
            end
         end
         S_LOCKED: begin
            // A break wins over a coincident clr_err: the fault must be
            // seen and cleared explicitly afterwards.
            if (step_ok) begin
               if (wrap) begin
                  rev_d   = rev_q + 1'b1;
                  rev_p_d = 1'b1;
               end
            end else begin
               state_d = S_FAULT;
               err_d   = 1'b1;
            end
         end
         S_FAULT: begin
            if (clr_err) begin
               state_d = S_SEARCH;
               err_d   = 1'b0;
               rev_d   = '0;
               good_d  = 8'd0;
            end
         end
         default: state_d = S_SEARCH;
      endcase
   end

   always_comb begin
      idx_d    = legal ? dec_idx : idx_q;
      valid_d  = legal;
      phase_d  = legal ? (8'd1 << dec_idx) : 8'd0;
      locked_d = (state_d == S_LOCKED);
   end

   always_ff @(posedge c or posedge r) begin
      if (r) begin
         state_q  <= S_SEARCH;
         good_q   <= 8'd0;
         idx_q    <= 3'd0;
         phase_q  <= 8'd0;
         valid_q  <= 1'b0;
         locked_q <= 1'b0;
         err_q    <= 1'b0;
         rev_q    <= '0;
         rev_p_q  <= 1'b0;
      end else begin
         state_q  <= state_d;
         good_q   <= good_d;
         idx_q    <= idx_d;
         phase_q  <= phase_d;
         valid_q  <= valid_d;
         locked_q <= locked_d;
         err_q    <= err_d;
         rev_q    <= rev_d;
         rev_p_q  <= rev_p_d;
      end
   end

   assign idx     = idx_q;
   assign phase   = phase_q;
   assign valid   = valid_q;
   assign locked  = locked_q;
   assign err     = err_q;
   assign rev_cnt = rev_q;
   assign rev_p   = rev_p_q;

endmodule

// File: tb/tb_johnson_phase_decoder.sv
// Bench for johnson_phase_decoder: directed scenarios plus random
// stimulus against a behavioural model; two instances (CW=8, CW=2).
module tb_johnson_phase_decoder;

   logic       c = 1'b0;
   logic       r = 1'b1;
   logic [3:0] q = 4'b0;
   logic       clr_err = 1'b0;

   logic [2:0] idx, idx2;
   logic [7:0] phase, phase2;
   logic       valid, valid2, locked, locked2, err, err2, rev_p, rev_p2;
   logic [7:0] rev_cnt;
   logic [1:0] rev_cnt2;

   int total = 0;
   int bad = 0;

   always #5 c = ~c;

   johnson_phase_decoder #(.LOCK_COUNT(4), .CW(8)) u_dut (
      .c(c), .r(r), .q(q), .clr_err(clr_err),
      .idx(idx), .phase(phase), .valid(valid), .locked(locked),
      .err(err), .rev_cnt(rev_cnt), .rev_p(rev_p)
   );

   johnson_phase_decoder #(.LOCK_COUNT(4), .CW(2)) u_dut2 (
      .c(c), .r(r), .q(q), .clr_err(clr_err),
      .idx(idx2), .phase(phase2), .valid(valid2), .locked(locked2),
      .err(err2), .rev_cnt(rev_cnt2), .rev_p(rev_p2)
   );

   // Legal Johnson codes in phase order
   logic [3:0] codes [8] = '{4'b1000, 4'b1100, 4'b1110, 4'b1111,
                             4'b0111, 4'b0011, 4'b0001, 4'b0000};

   // Behavioural model: mode 0 search, 1 track, 2 locked, 3 fault
   int m_mode, m_good, m_idx, m_rev;
   bit m_prev_ok, m_err, m_revp;
   int jidx;

   task automatic chk(input string tag, input longint got, input longint exp);
      total++;
      if (got != exp) begin
         bad++;
         $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
      end
   endtask

   function automatic int decode(input logic [3:0] v);
      for (int i = 0; i < 8; i++)
         if (codes[i] == v) return i;
      return -1;
   endfunction

   task automatic m_reset();
      m_mode = 0; m_good = 0; m_idx = 0; m_rev = 0;
      m_prev_ok = 0; m_err = 0; m_revp = 0;
   endtask

   task automatic m_step(input logic [3:0] v, input bit clr);
      int  n;
      bit  ok;
      n = decode(v);
      ok = (n >= 0) && m_prev_ok && (n == (m_idx + 1) % 8);
      m_revp = 0;
      case (m_mode)
         0: if (n >= 0) begin m_mode = 1; m_good = 0; end
         1: if (ok) begin
               m_good++;
               if (m_good == 4) m_mode = 2;
            end else m_mode = 0;
         2: if (ok) begin
               if (n == 0) begin m_rev++; m_revp = 1; end
            end else begin
               m_mode = 3; m_err = 1;
            end
         default: if (clr) begin
               m_mode = 0; m_err = 0; m_rev = 0; m_good = 0;
            end
      endcase
      m_prev_ok = (n >= 0);
      if (n >= 0) m_idx = n;
   endtask

   task automatic check_all();
      chk("idx", idx, m_idx);
      chk("phase", phase, m_prev_ok ? (1 << m_idx) : 0);
      chk("valid", valid, m_prev_ok);
      chk("locked", locked, m_mode == 2);
      chk("err", err, m_err);
      chk("rev_cnt", rev_cnt, m_rev % 256);
      chk("rev_p", rev_p, m_revp);
      chk("rev_cnt2", rev_cnt2, m_rev % 4);
      chk("rev_p2", rev_p2, m_revp);
      chk("locked2", locked2, m_mode == 2);
   endtask

   // Called at a negedge; returns at the following negedge
   task automatic tick(input logic [3:0] v, input bit clr);
      q = v;
      clr_err = clr;
      @(posedge c);
      m_step(v, clr);
      #1;
      check_all();
      @(negedge c);
   endtask

   task automatic adv(input bit clr);
      tick(codes[jidx], clr);
      jidx = (jidx + 1) % 8;
   endtask

   function automatic logic [3:0] rand_illegal();
      logic [3:0] v;
      do v = 4'($urandom % 16); while (decode(v) >= 0);
      return v;
   endfunction

   initial begin
      int p;
      m_reset();
      jidx = 0;
      #2;
      chk("rst_idx", idx, 0);
      chk("rst_phase", phase, 0);
      chk("rst_valid", valid, 0);
      chk("rst_locked", locked, 0);
      chk("rst_err", err, 0);
      chk("rst_rev", rev_cnt, 0);
      chk("rst_revp", rev_p, 0);
      @(negedge c);
      r = 1'b0;

      // Free run 40 edges
      for (int e = 1; e <= 40; e++) begin
         adv(0);
         if (e == 4) chk("unlocked_e4", locked, 0);
         if (e == 5) chk("locked_e5", locked, 1);
         if (e == 9 || e == 17 || e == 25 || e == 33)
            chk("revp_e", rev_p, 1);
         if (e == 33) chk("rev4", rev_cnt, 4);
         if (e == 33) chk("rev2_wrap", rev_cnt2, 0);
         if (e == 1) chk("phase_e1", phase, 8'h01);
         if (e == 8) chk("phase_e8", phase, 8'h80);
      end

      // Glitch while locked
      tick(4'b1010, 0);
      jidx = (jidx + 1) % 8;
      chk("glitch_valid", valid, 0);
      chk("glitch_phase", phase, 0);
      chk("glitch_locked", locked, 0);
      chk("glitch_err", err, 1);
      chk("glitch_rev", rev_cnt, 4);
      for (int i = 0; i < 10; i++) adv(0);
      chk("no_relock", locked, 0);
      chk("err_sticky", err, 1);

      // Clear fault, then re-lock
      adv(1);
      chk("clr_err", err, 0);
      chk("clr_rev", rev_cnt, 0);
      for (int i = 0; i < 4; i++) adv(0);
      chk("relock_early", locked, 0);
      adv(0);
      chk("relock", locked, 1);

      // Skip in TRACK: 7,0,1,2 then 4
      tick(4'b1010, 0);
      tick(4'b1010, 1);
      jidx = 7;
      for (int i = 0; i < 4; i++) adv(0);
      jidx = 4;
      adv(0);
      chk("skip_locked", locked, 0);
      chk("skip_err", err, 0);
      for (int i = 0; i < 8; i++) adv(0);
      chk("skip_relock", locked, 1);

      // Repeat code with clr_err in LOCKED: fault wins
      jidx = (jidx + 7) % 8;
      adv(1);
      chk("sim_err", err, 1);
      chk("sim_locked", locked, 0);
      adv(0);
      chk("sim_hold", err, 1);
      adv(1);
      chk("sim_clear", err, 0);

      // Random stimulus
      for (int i = 0; i < 600; i++) begin
         p = int'($urandom % 100);
         if (p < 85) adv(($urandom % 100) < 5);
         else if (p < 90) tick(rand_illegal(), ($urandom % 100) < 30);
         else if (p < 94) begin jidx = (jidx + 1) % 8; adv(0); end
         else if (p < 97) begin jidx = (jidx + 7) % 8; adv(0); end
         else begin jidx = int'($urandom % 8); adv(1); end
      end

      // Asynchronous reset mid-cycle
      @(posedge c);
      #3;
      r = 1'b1;
      #1;
      m_reset();
      chk("arst_idx", idx, 0);
      chk("arst_phase", phase, 0);
      chk("arst_valid", valid, 0);
      chk("arst_locked", locked, 0);
      chk("arst_err", err, 0);
      chk("arst_rev", rev_cnt, 0);
      chk("arst_revp", rev_p, 0);
      chk("arst_rev2", rev_cnt2, 0);
      @(negedge c);
      r = 1'b0;
      jidx = 0;
      for (int i = 0; i < 12; i++) adv(0);
      chk("post_rst_rev", rev_cnt, 1);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
